// File: rtl/seq_mac_result_drain.sv
// seq_mac_result_drain: captures the M x N matrix of 32-bit MAC accumulators on a
// valid/ready handshake, then streams it out one row per beat after requantisation
// (arithmetic right shift, round-half-up, saturate to signed OUT_WIDTH).
// Ports:
//   clk_i, rst_ni      clock (rising edge), asynchronous active-low reset
//   valid_in/ready_in  capture handshake with the MAC
//   D_in, shift_i      accumulator matrix [row][col] and right-shift amount, sampled on capture
//   out_valid_o/out_ready_i  row beat handshake with the consumer
//   out_data_o         requantised row, element n = column n
//   out_row_o          row index of the presented beat
//   out_last_o         beat is row M-1
//   sat_o              at least one element of the beat saturated
module seq_mac_result_drain #(
  parameter int M         = 2,
  parameter int N         = 2,
  parameter int OUT_WIDTH = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             valid_in,
  output logic                             ready_in,
  input  logic [M-1:0][N-1:0][31:0]        D_in,
  input  logic [4:0]                       shift_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [N-1:0][OUT_WIDTH-1:0]      out_data_o,
  output logic [$clog2(M):0]               out_row_o,
  output logic                             out_last_o,
  output logic                             sat_o
);

  localparam int RW = $clog2(M) + 1;
  localparam int RI = (M > 1) ? $clog2(M) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(M - 1);
  localparam logic signed [32:0] MAXV = (33'sd1 <<< (OUT_WIDTH - 1)) - 33'sd1;
  localparam logic signed [32:0] MINV = -(33'sd1 <<< (OUT_WIDTH - 1));

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  state_t                       state_q, state_d;
  logic [RW-1:0]                row_q, row_d;
  logic [M-1:0][N-1:0][31:0]    buf_q;
  logic [4:0]                   shift_q;

  logic                         last_row;
  logic                         capture;
  logic                         accept;
  logic [RI-1:0]                row_idx;
  logic [N-1:0][OUT_WIDTH:0]    res;

  // Returns {saturated, y[OUT_WIDTH-1:0]}; 33-bit arithmetic keeps the rounding add from overflowing.
  function automatic logic [OUT_WIDTH:0] requant(input logic [31:0] x, input logic [4:0] s);
    logic signed [32:0] xe;
    logic signed [32:0] rnd;
    logic signed [32:0] y;
    xe = {x[31], x};
    if (s == 5'd0) begin
      rnd = '0;
    end else begin
      rnd = 33'sd1 <<< (s - 5'd1);
    end
    y = (xe + rnd) >>> s;
    if (y > MAXV) begin
      requant = {1'b1, MAXV[OUT_WIDTH-1:0]};
    end else if (y < MINV) begin
      requant = {1'b1, MINV[OUT_WIDTH-1:0]};
    end else begin
      requant = {1'b0, y[OUT_WIDTH-1:0]};
    end
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      row_q   <= '0;
      buf_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      if (capture) begin
        buf_q   <= D_in;
        shift_q <= shift_i;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    out_valid_o = (state_q == DRAIN);
    last_row    = (row_q == LAST_ROW);
    out_last_o  = out_valid_o & last_row;
    accept      = out_valid_o & out_ready_i;
    // The final beat frees the buffer in the same cycle it leaves, so a new matrix
    // may be captured then; ready_in deliberately ignores valid_in.
    ready_in    = (state_q == IDLE) | (out_last_o & out_ready_i);
    capture     = valid_in & ready_in;
    if (capture) begin
      state_d = DRAIN;
      row_d   = '0;
    end else if (accept) begin
      if (last_row) begin
        state_d = IDLE;
        row_d   = '0;
      end else begin
        row_d = row_q + RW'(1);
      end
    end
  end

  always_comb begin
    row_idx    = row_q[RI-1:0];
    res        = '0;
    out_data_o = '0;
    sat_o      = 1'b0;
    for (int unsigned n = 0; n < N; n++) begin
      res[n]        = requant(buf_q[row_idx][n], shift_q);
      out_data_o[n] = res[n][OUT_WIDTH-1:0];
      sat_o         = sat_o | res[n][OUT_WIDTH];
    end
    sat_o = sat_o & out_valid_o;
  end

  assign out_row_o = row_q;

endmodule
